// File: rtl/redmule_pkg.sv
// Shared RedMulE constants and the TCDM traffic generator state encoding.
package redmule_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned ID_W       = 8;
    localparam int unsigned TG_MAX_OUT = 4;

    typedef enum logic [2:0] {
        TG_IDLE,
        TG_WRITE,
        TG_WDRAIN,
        TG_READ,
        TG_RDRAIN
    } tg_state_e;

endpackage

// File: rtl/redmule_tg_pattern.sv
// Beat-address to data pattern: 32-bit word k of a beat carries address + 4k.
module redmule_tg_pattern #(
    parameter int unsigned DW = redmule_pkg::DATA_W
) (
    input  logic [31:0]   addr_i,
    output logic [DW-1:0] pattern_o
);

    localparam int unsigned NW = DW / 32;

    always_comb begin
        pattern_o = '0;
        for (int k = 0; k < NW; k++) begin
            pattern_o[k*32 +: 32] = addr_i + 32'(4 * k);
        end
    end

endmodule

// File: rtl/redmule_tcdm_traffic_gen.sv
// TCDM traffic generator: writes a strided address pattern, reads it back and
// counts mismatched read beats and response-ordering errors.
module redmule_tcdm_traffic_gen #(
    parameter int unsigned DW      = redmule_pkg::DATA_W,
    parameter int unsigned IW      = redmule_pkg::ID_W,
    parameter int unsigned MAX_OUT = redmule_pkg::TG_MAX_OUT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [31:0]     base_addr_i,
    input  logic [31:0]     stride_i,
    input  logic [15:0]     len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [15:0]     err_cnt_o,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [31:0]     req_add_o,
    output logic            req_wen_o,
    output logic [DW/8-1:0] req_be_o,
    output logic [DW-1:0]   req_data_o,
    output logic [IW-1:0]   req_id_o,
    input  logic            resp_valid_i,
    input  logic [DW-1:0]   resp_data_i,
    input  logic [IW-1:0]   resp_id_i
);

    import redmule_pkg::*;

    localparam logic [3:0] MaxOut = 4'(MAX_OUT);

    tg_state_e   state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] stride_q, stride_d;
    logic [15:0] len_q, len_d;
    logic [15:0] beat_q, beat_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rsp_idx_q, rsp_idx_d;
    logic [31:0] exp_addr_q, exp_addr_d;
    logic [3:0]  out_cnt_q, out_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        done_q, done_d;

    logic [DW-1:0] gen_pattern, chk_pattern;
    logic          req_valid, req_fire, last_beat;
    logic          rsp_active, rsp_take, rsp_stray, id_bad, data_bad;
    logic [1:0]    err_inc;
    logic [16:0]   err_sum;

    redmule_tg_pattern #(.DW(DW)) i_gen_pattern (.addr_i(addr_q),     .pattern_o(gen_pattern));
    redmule_tg_pattern #(.DW(DW)) i_chk_pattern (.addr_i(exp_addr_q), .pattern_o(chk_pattern));

    // Throttle uses only the registered count, so a freed slot is reused one cycle later.
    assign req_valid  = ((state_q == TG_WRITE) || (state_q == TG_READ)) && (out_cnt_q < MaxOut);
    assign req_fire   = req_valid && req_ready_i;
    assign last_beat  = (beat_q == len_q - 16'd1);
    assign rsp_active = resp_valid_i && (state_q != TG_IDLE);
    assign rsp_take   = rsp_active && (out_cnt_q != 4'd0);
    assign rsp_stray  = rsp_active && (out_cnt_q == 4'd0);
    assign id_bad     = rsp_take && (resp_id_i != rsp_idx_q[IW-1:0]);
    assign data_bad   = rsp_take && ((state_q == TG_READ) || (state_q == TG_RDRAIN))
                        && (resp_data_i != chk_pattern);
    assign err_inc    = 2'(rsp_stray) + 2'(id_bad) + 2'(data_bad);
    assign err_sum    = {1'b0, err_cnt_q} + 17'(err_inc);

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        stride_d   = stride_q;
        len_d      = len_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        rsp_idx_d  = rsp_idx_q;
        exp_addr_d = exp_addr_q;
        out_cnt_d  = out_cnt_q;
        done_d     = 1'b0;
        err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];

        unique case ({req_fire, rsp_take})
            2'b10:   out_cnt_d = out_cnt_q + 4'd1;
            2'b01:   out_cnt_d = out_cnt_q - 4'd1;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (rsp_take) begin
            rsp_idx_d  = rsp_idx_q + 16'd1;
            exp_addr_d = exp_addr_q + stride_q;
        end
        if (req_fire) begin
            beat_d = beat_q + 16'd1;
            addr_d = addr_q + stride_q;
        end

        unique case (state_q)
            TG_IDLE: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    stride_d   = stride_i;
                    len_d      = len_i;
                    beat_d     = '0;
                    addr_d     = base_addr_i;
                    rsp_idx_d  = '0;
                    exp_addr_d = base_addr_i;
                    out_cnt_d  = '0;
                    err_cnt_d  = '0;
                    if (len_i == 16'd0) done_d  = 1'b1;
                    else                state_d = TG_WRITE;
                end
            end
            TG_WRITE: if (req_fire && last_beat) state_d = TG_WDRAIN;
            TG_WDRAIN: begin
                if (out_cnt_q == 4'd0) begin
                    state_d    = TG_READ;
                    beat_d     = '0;
                    addr_d     = base_q;
                    rsp_idx_d  = '0;
                    exp_addr_d = base_q;
                end
            end
            TG_READ: if (req_fire && last_beat) state_d = TG_RDRAIN;
            TG_RDRAIN: begin
                if (out_cnt_q == 4'd0) begin
                    state_d = TG_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = TG_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= TG_IDLE;
            base_q     <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            addr_q     <= '0;
            rsp_idx_q  <= '0;
            exp_addr_q <= '0;
            out_cnt_q  <= '0;
            err_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            rsp_idx_q  <= rsp_idx_d;
            exp_addr_q <= exp_addr_d;
            out_cnt_q  <= out_cnt_d;
            err_cnt_q  <= err_cnt_d;
            done_q     <= done_d;
        end
    end

    assign busy_o      = (state_q != TG_IDLE);
    assign done_o      = done_q;
    assign err_cnt_o   = err_cnt_q;
    assign req_valid_o = req_valid;
    assign req_add_o   = req_valid ? addr_q : '0;
    assign req_wen_o   = (state_q != TG_WRITE);
    assign req_be_o    = req_valid ? '1 : '0;
    assign req_data_o  = (req_valid && (state_q == TG_WRITE)) ? gen_pattern : '0;
    assign req_id_o    = req_valid ? beat_q[IW-1:0] : '0;

endmodule

// File: tb/tb_redmule_tcdm_traffic_gen.sv
// Scoreboard bench: expected requests are queued per run, a memory/monitor
// process answers requests and compares every handshake against the queue.
module tb_redmule_tcdm_traffic_gen;

    import redmule_pkg::*;

    localparam int DW = DATA_W;
    localparam int IW = ID_W;
    localparam int MO = TG_MAX_OUT;

    logic            clk_i, rst_ni, start_i;
    logic [31:0]     base_addr_i, stride_i;
    logic [15:0]     len_i;
    logic            busy_o, done_o;
    logic [15:0]     err_cnt_o;
    logic            req_valid_o, req_ready_i, req_wen_o;
    logic [31:0]     req_add_o;
    logic [DW/8-1:0] req_be_o;
    logic [DW-1:0]   req_data_o, resp_data_i;
    logic [IW-1:0]   req_id_o, resp_id_i;
    logic            resp_valid_i;

    redmule_tcdm_traffic_gen #(.DW(DW), .IW(IW), .MAX_OUT(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .stride_i(stride_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_add_o(req_add_o),
        .req_wen_o(req_wen_o), .req_be_o(req_be_o), .req_data_o(req_data_o),
        .req_id_o(req_id_o), .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .resp_id_i(resp_id_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]   add;
        logic          wen;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } req_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } rsp_t;

    req_t exp_q[$];
    rsp_t rsp_q[$];
    logic [DW-1:0] mem [logic [31:0]];

    int total = 0;
    int bad   = 0;

    // run configuration, written by the stimulus, read by the memory/monitor
    bit rand_ready   = 0;
    int lat          = 1;
    int corrupt_beat = -1;
    int bad_id_beat  = -1;

    // monitor state
    int   cyc = 0, out_cnt = 0, max_out = 0, rd_cnt = 0;
    int   wr_first = -1, wr_last = -1, rd_first = -1, rd_last = -1;
    logic stall = 1'b0;
    logic [31:0]   h_add;
    logic          h_wen;
    logic [DW-1:0] h_data;
    logic [IW-1:0] h_id;
    req_t e;
    rsp_t r;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic          rsp_now;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input logic [31:0] a);
        logic [DW-1:0] p;
        p = '0;
        for (int k = 0; k < DW / 32; k++) p[k*32 +: 32] = a + 32'(4 * k);
        return p;
    endfunction

    // Memory model and request monitor, acting on the falling edge.
    initial begin
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_data_i  = '0;
        resp_id_i    = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                rsp_q.delete();
                out_cnt      = 0;
                stall        = 1'b0;
                req_ready_i  = 1'b0;
                resp_valid_i = 1'b0;
                continue;
            end
            if (start_i) begin
                max_out  = 0;
                rd_cnt   = 0;
                wr_first = -1; wr_last = -1; rd_first = -1; rd_last = -1;
            end
            if (out_cnt > max_out) max_out = out_cnt;
            if (out_cnt >= MO) check("throttle_valid_low", req_valid_o, 0);

            rsp_now = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
            if (rsp_now) begin
                r = rsp_q.pop_front();
                resp_valid_i = 1'b1;
                resp_data_i  = r.data;
                resp_id_i    = r.id;
            end else begin
                resp_valid_i = 1'b0;
                resp_data_i  = '0;
                resp_id_i    = '0;
            end

            if (stall) begin
                check("stall_valid", req_valid_o, 1);
                check("stall_add", req_add_o, h_add);
                check("stall_wen", req_wen_o, h_wen);
                check("stall_data", req_data_o, h_data);
                check("stall_id", req_id_o, h_id);
            end

            req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

            if (req_valid_o && req_ready_i) begin
                check("outstanding_le_max", 64'(out_cnt < MO), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("req_add", req_add_o, e.add);
                    check("req_wen", req_wen_o, e.wen);
                    check("req_data", req_data_o, e.data);
                    check("req_id", req_id_o, e.id);
                    if (!e.wen) check("req_be", req_be_o, {(DW/8){1'b1}});
                end
                rid = req_id_o;
                if (!req_wen_o) begin
                    mem[req_add_o] = req_data_o;
                    rdata = '1;
                    if (wr_first < 0) wr_first = cyc;
                    wr_last = cyc;
                end else begin
                    rdata = mem.exists(req_add_o) ? mem[req_add_o] : '0;
                    if (rd_cnt == corrupt_beat) rdata[0] = ~rdata[0];
                    if (rd_cnt == bad_id_beat)  rid[0]   = ~rid[0];
                    rd_cnt++;
                    if (rd_first < 0) rd_first = cyc;
                    rd_last = cyc;
                end
                rsp_q.push_back('{due: cyc + lat, data: rdata, id: rid});
                out_cnt++;
            end
            if (rsp_now) out_cnt--;

            stall  = req_valid_o && !req_ready_i;
            h_add  = req_add_o;
            h_wen  = req_wen_o;
            h_data = req_data_o;
            h_id   = req_id_o;
        end
    end

    task automatic push_expected(input logic [31:0] base, input logic [31:0] stride, input int len);
        logic [31:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 32'(i) * stride;
            exp_q.push_back('{add: a, wen: 1'b0, data: pattern(a), id: IW'(i)});
        end
        for (int i = 0; i < len; i++) begin
            a = base + 32'(i) * stride;
            exp_q.push_back('{add: a, wen: 1'b1, data: '0, id: IW'(i)});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_cnt_o, 0);
        check({tag, "_valid"}, req_valid_o, 0);
        check({tag, "_add"}, req_add_o, 0);
        check({tag, "_data"}, req_data_o, 0);
        check({tag, "_be"}, req_be_o, 0);
        check({tag, "_id"}, req_id_o, 0);
        check({tag, "_wen"}, req_wen_o, 1);
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [31:0] stride, input int len);
        push_expected(base, stride, len);
        @(posedge clk_i);
        #1;
        base_addr_i = base;
        stride_i    = stride;
        len_i       = 16'(len);
        start_i     = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic run(input string name, input logic [31:0] base, input logic [31:0] stride,
                       input int len, input bit rr, input int l, input int cb, input int bb,
                       input int exp_err, input bit b2b, input int exp_max);
        bit ok;
        rand_ready = rr; lat = l; corrupt_beat = cb; bad_id_beat = bb;
        start_run(base, stride, len);
        if (len == 0) begin
            check({name, "_no_valid"}, req_valid_o, 0);
            check({name, "_busy_low"}, busy_o, 0);
            ok = done_o;
        end else begin
            check({name, "_first_valid"}, req_valid_o, 1);
            ok = 0;
            for (int c = 0; c < 4000; c++) begin
                if (done_o) begin ok = 1; break; end
                @(posedge clk_i);
                #1;
            end
        end
        check({name, "_done"}, ok, 1);
        if (!ok) begin
            apply_reset();
            return;
        end
        check({name, "_err_cnt"}, err_cnt_o, 64'(exp_err));
        check({name, "_idle_at_done"}, busy_o, 0);
        check({name, "_all_reqs_seen"}, 64'(exp_q.size()), 0);
        check({name, "_all_rsps_sent"}, 64'(rsp_q.size()), 0);
        if (b2b) begin
            check({name, "_wr_back_to_back"}, 64'(wr_last - wr_first), 64'(len - 1));
            check({name, "_rd_back_to_back"}, 64'(rd_last - rd_first), 64'(len - 1));
        end
        if (exp_max >= 0) check({name, "_max_outstanding"}, 64'(max_out), 64'(exp_max));
        @(posedge clk_i);
        #1;
        check({name, "_done_single"}, done_o, 0);
        check({name, "_err_hold"}, err_cnt_o, 64'(exp_err));
    endtask

    initial begin
        bit found;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        stride_i    = '0;
        len_i       = '0;
        #12;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        run("basic",      32'h1C010000, 32'(DW / 8), 8, 0, 1, -1, -1, 0, 1, -1);
        run("stall",      32'h1C020000, 32'(DW / 8), 32, 1, 2, -1, -1, 0, 0, -1);
        run("corrupt",    32'h1C030000, 32'h10, 8, 0, 1, 3, -1, 1, 0, -1);
        run("corrupt_id", 32'h1C040000, 32'h10, 8, 0, 1, 3, 5, 2, 0, -1);
        run("wrap_addr",  32'hFFFFFFE0, 32'h20, 2, 0, 1, -1, -1, 0, 0, -1);
        run("wrap_pat",   32'hFFFFFFFC, 32'h8, 3, 1, 1, -1, -1, 0, 0, -1);
        run("len0",       32'h1C050000, 32'h8, 0, 0, 1, -1, -1, 0, 0, -1);
        run("lat10",      32'h1C060000, 32'h8, 8, 0, 10, -1, -1, 0, 0, MO);

        // asynchronous reset during the read phase
        rand_ready = 0; lat = 3; corrupt_beat = -1; bad_id_beat = -1;
        start_run(32'h1C070000, 32'h8, 8);
        found = 0;
        for (int c = 0; c < 400; c++) begin
            if (req_valid_o && req_wen_o && busy_o) begin found = 1; break; end
            @(posedge clk_i);
            #1;
        end
        check("reach_read_phase", found, 1);
        #2 rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        run("after_reset", 32'h1C010000, 32'(DW / 8), 8, 0, 1, -1, -1, 0, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/redmule_tcdm_traffic_gen.md
REDMULE_TCDM_TRAFFIC_GEN -- requirements
Module: redmule_tcdm_traffic_gen

Interface
REQ-001 Parameters: DW default redmule_pkg::DATA_W, request/response data width; IW default redmule_pkg::ID_W, ID width; MAX_OUT default 4, max outstanding requests (1..15).
REQ-002 clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 start_i  in  1  one-cycle start pulse, sampled only in IDLE.
REQ-004 base_addr_i  in  32  first beat address, word aligned; stride_i  in  32  byte increment per beat; len_i  in  16  beats per phase.
REQ-005 busy_o  out  1  high outside IDLE; done_o  out  1  one-cycle completion pulse; err_cnt_o  out  16  mismatched read beats, saturating.
REQ-006 req_valid_o  out  1; req_ready_i  in  1; req_add_o  out  32; req_wen_o  out  1 (1=read, 0=write); req_be_o  out  DW/8; req_data_o  out  DW; req_id_o  out  IW.
REQ-007 resp_valid_i  in  1; resp_data_i  in  DW; resp_id_i  in  IW; responses in order, one per accepted request, reads and writes alike.

Function
REQ-008 FSM states: IDLE, WRITE, WDRAIN, READ, RDRAIN; start_i in IDLE latches inputs, clears err_cnt_o, enters WRITE; len_i=0 at start -> no requests, done_o next cycle, back to IDLE.
REQ-009 Beat i address = base + i*stride, modulo 2^32 (wrap-around silent); 32-bit word k of beat i carries pattern address+4k, modulo 2^32.
REQ-010 WRITE: issue beats 0..len-1 with req_wen_o=0, req_be_o all ones; after last handshake -> WDRAIN.
REQ-011 WDRAIN: wait outstanding=0, then READ with beat index reset to 0.
REQ-012 READ: issue beats 0..len-1 with req_wen_o=1, req_data_o=0; after last handshake -> RDRAIN; RDRAIN waits outstanding=0, pulses done_o, returns IDLE.
REQ-013 Handshake: request transfers when req_valid_o and req_ready_i both high; while valid and not ready, add/wen/be/data/id held stable; valid never withdrawn before transfer.
REQ-014 req_valid_o low whenever outstanding=MAX_OUT; request issue valid in same cycle as a response that frees a slot is not allowed (registered throttle, one cycle bubble).
REQ-015 Outstanding counter: +1 on request transfer, -1 on resp_valid_i, unchanged on both in same cycle; resp_valid_i at outstanding=0 ignored, counted as error.
REQ-016 req_id_o = beat index low IW bits; expected response id tracked by separate in-order counter; id mismatch counts one error.
REQ-017 Read response: any word differing from expected pattern -> err_cnt_o +1 per beat (not per word); write response data ignored.
REQ-018 err_cnt_o saturates at 16'hFFFF; holds value after done_o until next start.
REQ-019 Request issue latency: first req_valid_o one cycle after start_i capture; back-to-back beats every cycle while ready and slots free.

Reset
REQ-020 Reset asynchronous active-low at any time, including mid-burst: FSM IDLE, busy_o=0, done_o=0, err_cnt_o=0, req_valid_o=0, req_add_o/req_data_o/req_be_o/req_id_o=0, req_wen_o=1, counters 0; in-flight responses after reset ignored.

Structure
REQ-021 Shared package redmule_pkg holds FSM state enum tg_state_e and MAX_OUT default constant; DATA_W/ID_W reused.
REQ-022 One sub-module natural: redmule_tg_pattern (combinational beat-address -> DW pattern), instanced for generation and check.

Verification
REQ-023 base=0x1C010000, stride=DW/8, len=8, memory always ready -> 8 writes then 8 reads, done_o once, err_cnt_o=0, beats back-to-back.
REQ-024 Memory 50% random ready stall, len=32 -> request fields stable while stalled, err_cnt_o=0, outstanding never exceeds MAX_OUT.
REQ-025 Memory corrupts one word of read beat 3, len=8 -> err_cnt_o=1; wrong resp_id on beat 5 -> err_cnt_o=2.
REQ-026 base=0xFFFFFFE0, stride=0x20, len=2 -> beat1 address 0x00000000, pattern wraps, err_cnt_o=0.
REQ-027 len=0 -> no req_valid_o, done_o one cycle after start; rst_ni low mid-READ -> all outputs reset values within same cycle, later start completes cleanly.
REQ-028 Response latency 10 cycles, MAX_OUT=4 -> exactly 4 outstanding, req_valid_o low until response, done_o after last response.
